// File: rtl/l1_d_pkg.sv
// Shared constants, FSM state type and address field helpers for the L1 D-cache controller.
package l1_d_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned INDEX_W  = 6;
  localparam int unsigned OFFSET_W = 6;
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned SETS     = 1 << INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    REFILL_WAIT,
    REFILL_DONE,
    WT_WAIT,
    RESP
  } state_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/l1_d_tag_array.sv
// Valid/tag store: combinational read, synchronous write on refill, async clear on nrst.
module l1_d_tag_array
  import l1_d_pkg::*;
(
  input  logic               clk,
  input  logic               nrst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q [SETS];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
      tag_q[wr_index]   <= wr_tag;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];

endmodule

// File: rtl/l1_d_controller.sv
// Direct-mapped, write-through, no-write-allocate L1 D-cache control stage.
// Optional hit/miss counters are enabled with `define L1D_PERF_CNT_EN.
module l1_d_controller
  import l1_d_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        read_C_L1,
  input  logic        write_C_L1,
  input  logic [31:0] address_C_L1,
  input  logic [31:0] write_data_C_L1,
  output logic        ready_L1_C,
  output logic [31:0] read_data_L1_C,
  output logic [5:0]  index,
  output logic [5:0]  offset,
  output logic        refill,
  output logic        update,
  output logic [31:0] update_word,
  input  logic [31:0] data_array_word,
  output logic        read_L1_L2,
  output logic        write_L1_L2,
  output logic [31:0] address_L1_L2,
  output logic [31:0] write_data_L1_L2,
  input  logic        ready_L2_L1
`ifdef L1D_PERF_CNT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  state_t             state;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        data_q;
  logic               load_q;
  logic               tag_valid;
  logic [TAG_W-1:0]   tag_rd;
  logic               hit;

  l1_d_tag_array u_tags (
    .clk      (clk),
    .nrst     (nrst),
    .rd_index (index),
    .rd_valid (tag_valid),
    .rd_tag   (tag_rd),
    .wr_en    (refill),
    .wr_index (index),
    .wr_tag   (get_tag(addr_q))
  );

  assign index  = get_index(addr_q);
  assign offset = get_offset(addr_q);
  assign hit    = tag_valid && (tag_rd == get_tag(addr_q));

  // These depend on same-cycle inputs (tag lookup, L2 handshake, array read),
  // so they cannot be registered without breaking the cycle-exact timing.
  assign refill         = (state == REFILL_WAIT) && ready_L2_L1;
  assign update         = (state == COMPARE) && !load_q && hit;
  assign update_word    = update ? data_q : '0;
  assign read_data_L1_C = (state == RESP && load_q) ? data_array_word : '0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state            <= IDLE;
      addr_q           <= '0;
      data_q           <= '0;
      load_q           <= 1'b0;
      ready_L1_C       <= 1'b0;
      read_L1_L2       <= 1'b0;
      write_L1_L2      <= 1'b0;
      address_L1_L2    <= '0;
      write_data_L1_L2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read_C_L1 || write_C_L1) begin
            addr_q <= address_C_L1;
            data_q <= write_data_C_L1;
            load_q <= read_C_L1;
            state  <= COMPARE;
          end
        end
        COMPARE: begin
          if (load_q) begin
            if (hit) begin
              ready_L1_C <= 1'b1;
              state      <= RESP;
            end else begin
              read_L1_L2    <= 1'b1;
              address_L1_L2 <= {get_tag(addr_q), get_index(addr_q), {OFFSET_W{1'b0}}};
              state         <= REFILL_WAIT;
            end
          end else begin
            write_L1_L2      <= 1'b1;
            address_L1_L2    <= addr_q;
            write_data_L1_L2 <= data_q;
            state            <= WT_WAIT;
          end
        end
        REFILL_WAIT: begin
          if (ready_L2_L1) begin
            read_L1_L2 <= 1'b0;
            state      <= REFILL_DONE;
          end
        end
        REFILL_DONE: state <= COMPARE;
        WT_WAIT: begin
          if (ready_L2_L1) begin
            write_L1_L2 <= 1'b0;
            ready_L1_C  <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          ready_L1_C <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef L1D_PERF_CNT_EN
  // recmp_q marks the compare that follows a refill so it is not counted twice.
  logic recmp_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      recmp_q  <= 1'b0;
    end else begin
      if (state == REFILL_DONE)
        recmp_q <= 1'b1;
      else if (state == IDLE)
        recmp_q <= 1'b0;
      if (state == COMPARE && load_q && !recmp_q) begin
        if (hit) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: doc/l1_d_controller.md
Name: l1_d_controller

Overview:
- Control stage directly upstream of the L1 D-cache data array. 64 sets, direct-mapped, 64-byte lines.
- Accepts core load/store requests and holds the tag/valid store.
- Drives index, offset, refill and update into the data array; returns the array's 32-bit word to the core.
- Issues line refills to L2 on read miss. Write-through, no-write-allocate: every store is forwarded to L2.

Parameters:
- ADDR_W, 32, core byte-address width
- INDEX_W, 6, set-index bits (64 sets)
- OFFSET_W, 6, byte offset within a 512-bit line
- TAG_W, ADDR_W-INDEX_W-OFFSET_W = 20, tag bits

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- read_C_L1  in  1  core load request
- write_C_L1  in  1  core store request (ignored if read_C_L1 is also high; load wins)
- address_C_L1  in  32  core byte address
- write_data_C_L1  in  32  store word
- ready_L1_C  out  1  one-cycle completion pulse to core
- read_data_L1_C  out  32  load word, valid while ready_L1_C=1
- index  out  6  set index to data array
- offset  out  6  byte offset to data array
- refill  out  1  one-cycle pulse: data array captures read_data_L2_L1
- update  out  1  one-cycle pulse: store-hit word write at index/offset
- update_word  out  32  word for the update merge
- data_array_word  in  32  registered word from data array
- read_L1_L2  out  1  line read request to L2, held until ready_L2_L1
- write_L1_L2  out  1  word write request to L2, held until ready_L2_L1
- address_L1_L2  out  32  line address on read (offset zeroed), byte address on write
- write_data_L1_L2  out  32  store word to L2
- ready_L2_L1  in  1  L2 completion pulse

Behaviour:
- Reset (asynchronous, nrst=0):
  - State goes to IDLE; all valid bits and tags clear.
  - All outputs 0; latched address and data 0.
- States: IDLE, COMPARE, REFILL_WAIT, REFILL_DONE, WT_WAIT, RESP.
- IDLE:
  - Request accepted when read_C_L1 or write_C_L1 is high; address, op and data latched at that edge -> COMPARE.
  - Core must hold its request low after ready_L1_C until it issues the next one.
- COMPARE:
  - index/offset driven from the latched address; hit = valid[index] && tag[index]==addr tag.
  - Load hit -> RESP.
  - Load miss -> REFILL_WAIT, with read_L1_L2=1 and address_L1_L2={tag,index,6'b0}.
  - Store, hit or miss -> WT_WAIT with write_L1_L2=1.
  - On a store hit only, update=1 and update_word=latched data for exactly one cycle, in the COMPARE cycle.
- index/offset hold the latched values in every non-IDLE state, so the data array's registered read tracks the request.
- REFILL_WAIT:
  - Holds read_L1_L2 until ready_L2_L1=1.
  - In that cycle: refill=1, valid[index]=1, tag[index]=latched tag, read_L1_L2 drops -> REFILL_DONE.
- REFILL_DONE: one bubble so the array latches the new line -> COMPARE (guaranteed hit).
- WT_WAIT: holds write_L1_L2 until ready_L2_L1=1 -> RESP.
- RESP:
  - ready_L1_C=1 for one cycle -> IDLE.
  - For loads, read_data_L1_C=data_array_word; for stores it is 0.
- Latency (accept edge = cycle 0):
  - Load hit: ready_L1_C in cycle 2.
  - Load miss: ready_L1_C at L2 completion + 3 cycles.
  - Store: ready_L1_C at L2 completion + 1 cycle.
- ready_L2_L1 in IDLE, COMPARE or RESP is ignored.
- Reset mid-refill: the request is abandoned; the line is not validated; read_L1_L2 drops asynchronously.
- Misaligned offset[1:0] is ignored (word-aligned).

Optional Feature:
- Macro: L1D_PERF_CNT_EN.
- When defined, adds outputs hit_cnt and miss_cnt, 32 bits each.
  - Counters increment in COMPARE on load hit or load miss respectively; the re-compare after a refill is not counted.
  - Counters saturate at 32'hFFFFFFFF and reset to 0.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package l1_d_pkg holds:
  - the state enum;
  - INDEX_W, OFFSET_W and TAG_W constants;
  - tag/index/offset field-extraction functions.
- One sub-module, l1_d_tag_array: 64 entries of {valid, tag}, combinational read, synchronous write on refill, asynchronous clear on nrst.

Test Plan:
- Cold load 0x0000_1040, L2 returns after 4 cycles -> read_L1_L2 with address 0x0000_1040, one refill pulse, ready_L1_C at cycle 7, data = word 0 of the line.
- Repeat load 0x0000_1044 -> no L2 traffic, ready_L1_C in cycle 2, word 1 returned.
- Store 0xDEADBEEF to 0x0000_1048 (hit) -> update pulse with offset 0x08, write_L1_L2 to 0x0000_1048, then ready_L1_C; following load returns 0xDEADBEEF.
- Store to 0x0002_1048 (same index, different tag) -> no update, no refill, L2 write only; load of 0x0000_1048 still hits.
- Conflict load 0x0002_1040 -> miss, refill, tag replaced; subsequent load of 0x0000_1040 misses again.
- nrst asserted during REFILL_WAIT -> read_L1_L2 drops immediately; after release, the same load misses (valid=0).
